// File: rtl/pipe_dp_pkg.sv
// Shared constants for the two-stage register-file datapath: default sizes and ALU op-codes.
package pipe_dp_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_NREGS = 8;

  localparam logic [3:0] OP_PASS_R = 4'd0;
  localparam logic [3:0] OP_PASS_S = 4'd1;
  localparam logic [3:0] OP_ADD    = 4'd2;
  localparam logic [3:0] OP_SUB    = 4'd3;
  localparam logic [3:0] OP_AND    = 4'd4;
  localparam logic [3:0] OP_OR     = 4'd5;
  localparam logic [3:0] OP_XOR    = 4'd6;
  localparam logic [3:0] OP_NOT    = 4'd7;
  localparam logic [3:0] OP_SHL    = 4'd8;
  localparam logic [3:0] OP_SHR    = 4'd9;
  localparam logic [3:0] OP_INC    = 4'd10;
  localparam logic [3:0] OP_DEC    = 4'd11;

endpackage

// File: rtl/pipe_datapath_alu.sv
// Combinational ALU between the D and X stages; result carries an extra bit for the carry flag.
module alu_p
  import pipe_dp_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] r_i,
  input  logic [WIDTH-1:0] s_i,
  input  logic [3:0]       op_i,
  output logic [WIDTH-1:0] res_o,
  output logic             n_o,
  output logic             z_o,
  output logic             c_o
);

  logic [WIDTH:0] ext;

  // Bit WIDTH of ext is the carry; logic ops leave it 0. SUB/DEC carry means "no borrow".
  always_comb begin
    ext = '0;
    case (op_i)
      OP_PASS_R: ext = {1'b0, r_i};
      OP_PASS_S: ext = {1'b0, s_i};
      OP_ADD:    ext = {1'b0, r_i} + {1'b0, s_i};
      OP_SUB:    ext = {1'b0, r_i} + {1'b0, ~s_i} + (WIDTH+1)'(1);
      OP_AND:    ext = {1'b0, r_i & s_i};
      OP_OR:     ext = {1'b0, r_i | s_i};
      OP_XOR:    ext = {1'b0, r_i ^ s_i};
      OP_NOT:    ext = {1'b0, ~r_i};
      OP_SHL:    ext = {r_i, 1'b0};
      OP_SHR:    ext = {r_i[0], 1'b0, r_i[WIDTH-1:1]};
      OP_INC:    ext = {1'b0, r_i} + (WIDTH+1)'(1);
      OP_DEC:    ext = {1'b0, r_i} + {1'b0, {WIDTH{1'b1}}};
      default:   ext = '0;
    endcase
  end

  assign res_o = ext[WIDTH-1:0];
  assign c_o   = ext[WIDTH];
  assign n_o   = ext[WIDTH-1];
  assign z_o   = (ext[WIDTH-1:0] == '0);

endmodule

// File: rtl/pipe_datapath.sv
// Two-stage (D operands, X result) register-file datapath with valid/ready handshakes
// and a result bypass into operand capture.
module pipe_datapath
  import pipe_dp_pkg::*;
#(
  parameter  int WIDTH = DEF_WIDTH,
  parameter  int NREGS = DEF_NREGS,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             we,
  input  logic [AW-1:0]    r_adr,
  input  logic [AW-1:0]    s_adr,
  input  logic [AW-1:0]    w_adr,
  input  logic [3:0]       alu_op,
  input  logic             s_sel,
  input  logic [WIDTH-1:0] ds,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_out,
  output logic [WIDTH-1:0] reg_out,
  output logic             n,
  output logic             z,
  output logic             c
);

  logic [WIDTH-1:0] rf_q [NREGS];

  logic             vld_p1_q;
  logic [WIDTH-1:0] opr_r_p1_q;
  logic [WIDTH-1:0] opr_s_p1_q;
  logic [3:0]       op_p1_q;
  logic             we_p1_q;
  logic [AW-1:0]    wadr_p1_q;

  logic             vld_p2_q;
  logic [WIDTH-1:0] res_p2_q;
  logic [WIDTH-1:0] opr_r_p2_q;
  logic             n_p2_q;
  logic             z_p2_q;
  logic             c_p2_q;

  logic             adv_p1;
  logic             accept;
  logic             wr_en;
  logic             fwd_r;
  logic             fwd_s;
  logic [WIDTH-1:0] opr_r_d;
  logic [WIDTH-1:0] opr_s_d;
  logic [WIDTH-1:0] alu_res;
  logic             alu_n;
  logic             alu_z;
  logic             alu_c;

  assign adv_p1   = vld_p1_q && (!vld_p2_q || out_ready);
  assign in_ready = !reset && (!vld_p1_q || adv_p1);
  assign accept   = in_valid && in_ready;
  assign wr_en    = adv_p1 && we_p1_q;

  // An instruction accepted only while D advances, so the D result is exactly what it would have written.
  assign fwd_r   = wr_en && (wadr_p1_q == r_adr);
  assign fwd_s   = wr_en && (wadr_p1_q == s_adr);
  assign opr_r_d = fwd_r ? alu_res : rf_q[r_adr];
  assign opr_s_d = s_sel ? ds : (fwd_s ? alu_res : rf_q[s_adr]);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
    end else if (wr_en) begin
      rf_q[wadr_p1_q] <= alu_res;
    end
  end

  // ---- D stage: operands captured ----
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      vld_p1_q <= 1'b0;
    end else if (accept) begin
      vld_p1_q <= 1'b1;
    end else if (adv_p1) begin
      vld_p1_q <= 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (accept) begin
      opr_r_p1_q <= opr_r_d;
      opr_s_p1_q <= opr_s_d;
      op_p1_q    <= alu_op;
      we_p1_q    <= we;
      wadr_p1_q  <= w_adr;
    end
  end

  alu_p #(.WIDTH(WIDTH)) u_alu (
    .r_i   (opr_r_p1_q),
    .s_i   (opr_s_p1_q),
    .op_i  (op_p1_q),
    .res_o (alu_res),
    .n_o   (alu_n),
    .z_o   (alu_z),
    .c_o   (alu_c)
  );

  // ---- X stage: result registered, held while the consumer stalls ----
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      vld_p2_q   <= 1'b0;
      res_p2_q   <= '0;
      opr_r_p2_q <= '0;
      n_p2_q     <= 1'b0;
      z_p2_q     <= 1'b0;
      c_p2_q     <= 1'b0;
    end else if (adv_p1) begin
      vld_p2_q   <= 1'b1;
      res_p2_q   <= alu_res;
      opr_r_p2_q <= opr_r_p1_q;
      n_p2_q     <= alu_n;
      z_p2_q     <= alu_z;
      c_p2_q     <= alu_c;
    end else if (out_ready) begin
      vld_p2_q   <= 1'b0;
    end
  end

  assign out_valid = vld_p2_q;
  assign alu_out   = res_p2_q;
  assign reg_out   = opr_r_p2_q;
  assign n         = n_p2_q;
  assign z         = z_p2_q;
  assign c         = c_p2_q;

endmodule

// File: tb/tb_pipe_datapath.sv
// Bench for pipe_datapath: directed scenarios plus random traffic against an in-order ISA-level model.
module tb_pipe_datapath;

  localparam int W  = 16;
  localparam int NR = 8;
  localparam int AW = 3;

  logic          clock = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic          we;
  logic [AW-1:0] r_adr;
  logic [AW-1:0] s_adr;
  logic [AW-1:0] w_adr;
  logic [3:0]    alu_op;
  logic          s_sel;
  logic [W-1:0]  ds;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  alu_out;
  logic [W-1:0]  reg_out;
  logic          n;
  logic          z;
  logic          c;

  always #5 clock = ~clock;

  pipe_datapath #(.WIDTH(W), .NREGS(NR)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .we        (we),
    .r_adr     (r_adr),
    .s_adr     (s_adr),
    .w_adr     (w_adr),
    .alu_op    (alu_op),
    .s_sel     (s_sel),
    .ds        (ds),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .alu_out   (alu_out),
    .reg_out   (reg_out),
    .n         (n),
    .z         (z),
    .c         (c)
  );

  typedef struct {
    int alu;
    int rg;
    bit fn;
    bit fz;
    bit fc;
    int acyc;
  } exp_t;

  typedef struct {
    int alu;
    bit fn;
    bit fz;
    bit fc;
    int cyc;
    int lat;
  } got_t;

  exp_t expq[$];
  got_t got[$];
  int   mrf [NR];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  bit   acc_last;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Instruction semantics on plain integers, result reduced modulo 2^16.
  function automatic void model_alu(input int op, input int r, input int s,
                                    output int res, output bit cf);
    int t;
    cf = 1'b0;
    case (op)
      0:  t = r;
      1:  t = s;
      2:  begin t = r + s; cf = (t > 65535); end
      3:  begin t = r - s; cf = (r >= s); end
      4:  t = r & s;
      5:  t = r | s;
      6:  t = r ^ s;
      7:  t = 65535 - r;
      8:  begin t = r * 2; cf = (r >= 32768); end
      9:  begin t = r / 2; cf = (r % 2 == 1); end
      10: begin t = r + 1; cf = (r == 65535); end
      11: begin t = r - 1; cf = (r != 0); end
      default: t = 0;
    endcase
    res = t & 65535;
  endfunction

  task automatic model_accept();
    exp_t e;
    int   rv, sv, res;
    bit   cf;
    rv = mrf[int'(r_adr)];
    sv = s_sel ? int'(ds) : mrf[int'(s_adr)];
    model_alu(int'(alu_op), rv, sv, res, cf);
    e.alu  = res;
    e.rg   = rv;
    e.fn   = (res >= 32768);
    e.fz   = (res == 0);
    e.fc   = cf;
    e.acyc = cyc;
    expq.push_back(e);
    if (we) mrf[int'(w_adr)] = res;
  endtask

  task automatic model_flush();
    expq.delete();
    for (int i = 0; i < NR; i++) mrf[i] = 0;
  endtask

  // One clock: check outputs mid-cycle, update the model with the handshakes, then cross the edge.
  task automatic cycle();
    bit   acc, pop;
    got_t g;
    #4;
    if (out_valid === 1'b1) begin
      if (expq.size() == 0) begin
        chk("spurious_out_valid", 32'(out_valid), 32'd0);
      end else begin
        chk("alu_out", 32'(alu_out), 32'(expq[0].alu));
        chk("reg_out", 32'(reg_out), 32'(expq[0].rg));
        chk("flag_n", 32'(n), 32'(expq[0].fn));
        chk("flag_z", 32'(z), 32'(expq[0].fz));
        chk("flag_c", 32'(c), 32'(expq[0].fc));
      end
    end
    chk("in_ready", 32'(in_ready), 32'(!(expq.size() == 2 && !out_ready)));
    acc = in_valid && in_ready;
    pop = out_valid && out_ready;
    if (pop && expq.size() != 0) begin
      g.alu = int'(alu_out);
      g.fn  = n;
      g.fz  = z;
      g.fc  = c;
      g.cyc = cyc;
      g.lat = cyc - expq[0].acyc;
      got.push_back(g);
      void'(expq.pop_front());
    end
    if (acc) model_accept();
    acc_last = acc;
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic set_instr(input int op, input int ra, input int wa, input bit wev,
                           input bit ss, input int d);
    alu_op = 4'(op);
    r_adr  = AW'(ra);
    s_adr  = AW'(ra);
    w_adr  = AW'(wa);
    we     = wev;
    s_sel  = ss;
    ds     = W'(d);
  endtask

  task automatic issue(input int op, input int ra, input int wa, input bit wev,
                       input bit ss, input int d);
    int k;
    set_instr(op, ra, wa, wev, ss, d);
    in_valid = 1'b1;
    acc_last = 1'b0;
    k = 0;
    while (!acc_last && k < 20) begin
      cycle();
      k++;
    end
    if (!acc_last) chk("issue_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int k;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    k = 0;
    while (expq.size() != 0 && k < 30) begin
      cycle();
      k++;
    end
    chk("drain_left", 32'(expq.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle=%0d required=finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int base, nacc;
    logic [W-1:0] hold;

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    set_instr(0, 0, 0, 1'b0, 1'b0, 0);
    model_flush();
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_alu_out", 32'(alu_out), 32'd0);
    chk("rst_reg_out", 32'(reg_out), 32'd0);
    chk("rst_flags", {29'd0, n, z, c}, 32'd0);
    @(posedge clock); @(posedge clock); #1;
    reset = 1'b0;
    #1;
    chk("in_ready_after_rst", 32'(in_ready), 32'd1);

    // Bypass from a just-written register.
    base = got.size();
    issue(1, 0, 3, 1'b1, 1'b1, 'h1234);
    issue(0, 3, 0, 1'b0, 1'b0, 0);
    drain();
    chk("byp_first", 32'(got[base].alu), 32'h1234);
    chk("byp_alu", 32'(got[base+1].alu), 32'h1234);
    chk("byp_nz", {30'd0, got[base+1].fn, got[base+1].fz}, 32'd0);
    chk("latency", 32'(got[base].lat), 32'd2);
    chk("throughput", 32'(got[base+1].cyc - got[base].cyc), 32'd1);

    // Add wrap-around with carry.
    base = got.size();
    issue(1, 0, 3, 1'b1, 1'b1, 'hFFFF);
    issue(2, 3, 0, 1'b0, 1'b1, 'h0001);
    drain();
    chk("add_alu", 32'(got[base+1].alu), 32'h0000);
    chk("add_nzc", {29'd0, got[base+1].fn, got[base+1].fz, got[base+1].fc}, 32'b011);

    // Subtract with and without borrow.
    base = got.size();
    issue(1, 0, 1, 1'b1, 1'b1, 'h0005);
    issue(3, 1, 0, 1'b0, 1'b1, 'h0007);
    issue(3, 1, 0, 1'b0, 1'b1, 'h0005);
    drain();
    chk("sub_borrow_alu", 32'(got[base+1].alu), 32'hFFFE);
    chk("sub_borrow_nc", {30'd0, got[base+1].fn, got[base+1].fc}, 32'b10);
    chk("sub_eq_alu", 32'(got[base+2].alu), 32'h0000);
    chk("sub_eq_zc", {30'd0, got[base+2].fz, got[base+2].fc}, 32'b11);

    // Back-to-back increments of R2 through the bypass.
    issue(1, 0, 2, 1'b1, 1'b1, 0);
    drain();
    base = got.size();
    for (int i = 0; i < 5; i++) issue(10, 2, 2, 1'b1, 1'b0, 0);
    drain();
    for (int i = 0; i < 5; i++) begin
      chk("inc_alu", 32'(got[base+i].alu), 32'(i + 1));
      chk("inc_cycle", 32'(got[base+i].cyc - got[base].cyc), 32'(i));
    end

    // Stalled consumer: only two of three instructions fit.
    base = got.size();
    out_ready = 1'b0;
    nacc = 0;
    in_valid = 1'b1;
    set_instr(1, 0, 4, 1'b1, 1'b1, 'h11);
    for (int i = 0; i < 4; i++) begin
      cycle();
      if (acc_last) begin
        nacc++;
        if (nacc == 1) set_instr(1, 0, 5, 1'b1, 1'b1, 'h22);
        else set_instr(0, 4, 0, 1'b0, 1'b1, 0);
      end
    end
    chk("stall_accepted", 32'(nacc), 32'd2);
    chk("stall_in_ready", 32'(in_ready), 32'd0);
    hold = alu_out;
    cycle();
    chk("stall_hold", 32'(alu_out), 32'(hold));
    out_ready = 1'b1;
    acc_last = 1'b0;
    for (int i = 0; i < 10 && !acc_last; i++) cycle();
    chk("stall_third_acc", 32'(acc_last), 32'd1);
    drain();
    chk("order0", 32'(got[base].alu), 32'h11);
    chk("order1", 32'(got[base+1].alu), 32'h22);
    chk("order2", 32'(got[base+2].alu), 32'h11);

    // Reset with both stages full.
    out_ready = 1'b0;
    issue(1, 0, 6, 1'b1, 1'b1, 'hAAAA);
    issue(1, 0, 7, 1'b1, 1'b1, 'hBBBB);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    reset = 1'b1;
    #1;
    chk("flush_out_valid", 32'(out_valid), 32'd0);
    chk("flush_in_ready", 32'(in_ready), 32'd0);
    chk("flush_alu_out", 32'(alu_out), 32'd0);
    model_flush();
    @(posedge clock); #1;
    reset = 1'b0;
    out_ready = 1'b1;
    base = got.size();
    for (int i = 0; i < NR; i++) issue(0, i, 0, 1'b0, 1'b0, 0);
    drain();
    for (int i = 0; i < NR; i++) chk("flush_reg_zero", 32'(got[base+i].alu), 32'd0);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(9) < 7);
      out_ready = ($urandom_range(9) < 7);
      alu_op    = 4'($urandom_range(15));
      r_adr     = AW'($urandom_range(NR - 1));
      s_adr     = AW'($urandom_range(NR - 1));
      w_adr     = AW'($urandom_range(NR - 1));
      we        = ($urandom_range(3) != 0);
      s_sel     = $urandom_range(1);
      ds        = ($urandom_range(3) == 0) ? W'(16'hFFFF) : W'($urandom);
      cycle();
    end
    drain();
    cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
